// File: rtl/vram_dp.sv
// ---------------------------------------------------------------------------
// vram_dp: parametrised dual-port video RAM.
//   CPU port     : byte-enable writes and registered reads through a base-
//                  address window; ready/valid handshake (ready = FSM idle).
//   Display port : registered read, one-cycle latency, valid flag.
//   Clear engine : sweeps the whole array with a programmable fill value,
//                  one word per cycle, DEPTH cycles total.
//
// Parameters
//   ADDR_W  word-address bits, DEPTH = 1 << ADDR_W
//   BYTES   bytes per word, DATA_W = 8*BYTES
//   BASE    byte-address window base, aligned to DEPTH*BYTES
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req/we/be/addr/wdata    CPU request (one cycle per transfer)
//   cpu_ready                   combinational, high while the FSM is idle
//   cpu_rvalid/cpu_rdata        read response, cycle after acceptance
//   disp_en/disp_addr           display read request
//   disp_valid/disp_data        display read response
//   clr_start/clr_value         start a clear sweep with the given fill
//   busy/clr_done               sweep in progress / one-cycle completion pulse
//
// Optional feature macro: VRAM_CLEAR_ON_RESET_EN
//   When defined, a zero-fill sweep starts automatically right after reset.
// ---------------------------------------------------------------------------
module vram_dp #(
  parameter int unsigned  ADDR_W = 13,
  parameter int unsigned  BYTES  = 1,
  parameter logic [31:0]  BASE   = 32'h0000_0000,
  localparam int unsigned DATA_W = 8 * BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BYTES-1:0]  cpu_be,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned OFF    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned TAG_LO = ADDR_W + OFF;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              clr_we_c;
  logic              sweep_last_c;
  logic              init_hold_c;

  logic              hit_c;
  logic [ADDR_W-1:0] widx_c;
  logic              acc_c;
  logic              wr_acc_c;
  logic              rd_acc_c;

  // Low byte-offset bits never select anything; tie them off for lint.
  if (OFF > 0) begin : g_off
    logic unused_low;
    assign unused_low = ^cpu_addr[OFF-1:0];
  end

  // Pending power-on sweep: holds the port closed for the cycle between
  // reset release and the FSM entering CLEAR.
`ifdef VRAM_CLEAR_ON_RESET_EN
  logic init_pend_q;

  always_ff @(posedge clk) begin
    if (rst) init_pend_q <= 1'b1;
    else     init_pend_q <= 1'b0;
  end

  assign init_hold_c = init_pend_q;
`else
  assign init_hold_c = 1'b0;
`endif

  // Window decode and transfer acceptance.
  assign hit_c     = (cpu_addr[31:TAG_LO] == BASE[31:TAG_LO]);
  assign widx_c    = cpu_addr[TAG_LO-1:OFF];
  assign cpu_ready = (state_q == ST_IDLE) && !init_hold_c;
  assign acc_c     = cpu_req && cpu_ready;
  assign wr_acc_c  = acc_c && cpu_we;
  assign rd_acc_c  = acc_c && !cpu_we;

  // Clear FSM next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    clr_we_c     = 1'b0;
    sweep_last_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (init_hold_c) begin
          state_d = ST_CLEAR;
          fill_d  = '0;
          cnt_d   = '0;
        end else if (clr_start) begin
          state_d = ST_CLEAR;
          fill_d  = clr_value;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          sweep_last_c = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, handshake and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      busy       <= (state_d == ST_CLEAR);
      clr_done   <= sweep_last_c;
      cpu_rvalid <= rd_acc_c;
      if (rd_acc_c) cpu_rdata <= hit_c ? mem[widx_c] : '0;
      disp_valid <= disp_en;
      // Non-blocking read: a same-edge write is not visible here.
      if (disp_en) disp_data <= mem[disp_addr];
    end
  end

  // Array write port; CPU writes and sweep writes are mutually exclusive
  // because CPU transfers are only accepted while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we_c) begin
        mem[cnt_q] <= fill_q;
      end else if (wr_acc_c && hit_c) begin
        for (int b = 0; b < int'(BYTES); b++) begin
          if (cpu_be[b]) mem[widx_c][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_dp.sv
// ---------------------------------------------------------------------------
// tb_vram_dp: directed + randomized bench for vram_dp (ADDR_W=4, BYTES=4,
// BASE=0x1000). A word-array reference model predicts every registered
// output; each comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_vram_dp;

  localparam int unsigned TB_ADDR_W = 4;
  localparam int unsigned TB_BYTES  = 4;
  localparam int unsigned TB_DEPTH  = 16;
  localparam logic [31:0] TB_BASE   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        disp_en;
  logic [3:0]  disp_addr;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic        clr_start;
  logic [31:0] clr_value;
  logic        busy;
  logic        clr_done;

  vram_dp #(
    .ADDR_W (TB_ADDR_W),
    .BYTES  (TB_BYTES),
    .BASE   (TB_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .clr_start  (clr_start),
    .clr_value  (clr_value),
    .busy       (busy),
    .clr_done   (clr_done)
  );

  always #5 clk = ~clk;

  // Reference model: memory image plus expected registered outputs.
  logic [31:0] mem_m [TB_DEPTH];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_dvalid;
  logic [31:0] m_disp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_window(input logic [31:0] a);
    return (a >= TB_BASE) && (a < TB_BASE + TB_DEPTH * TB_BYTES);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - TB_BASE) / TB_BYTES);
  endfunction

  // One idle-state cycle: predict from the pre-edge model, clock, compare.
  task automatic cyc(input string tag);
    logic [31:0] w;
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    m_dvalid = disp_en;
    if (disp_en) m_disp = mem_m[disp_addr];
    m_rvalid = cpu_req && !cpu_we;
    if (cpu_req && !cpu_we) m_rdata = in_window(cpu_addr) ? mem_m[word_of(cpu_addr)] : 32'h0;
    if (cpu_req && cpu_we && in_window(cpu_addr)) begin
      w = mem_m[word_of(cpu_addr)];
      for (int b = 0; b < 4; b++) if (cpu_be[b]) w[8*b +: 8] = cpu_wdata[8*b +: 8];
      mem_m[word_of(cpu_addr)] = w;
    end
    step();
    chk({tag, "_rvalid"},  32'(cpu_rvalid), 32'(m_rvalid));
    chk({tag, "_rdata"},   cpu_rdata, m_rdata);
    chk({tag, "_dvalid"},  32'(disp_valid), 32'(m_dvalid));
    chk({tag, "_ddata"},   disp_data, m_disp);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_clrdone"}, 32'(clr_done), 32'd0);
  endtask

  task automatic cpu_wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    cyc(tag);
    cpu_req = 1'b0;
  endtask

  task automatic cpu_rd(input string tag, input logic [31:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    cyc(tag);
    cpu_req = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    m_rvalid = 1'b0; m_rdata = 32'h0; m_dvalid = 1'b0; m_disp = 32'h0;
    chk({tag, "_rvalid"},  32'(cpu_rvalid), 32'd0);
    chk({tag, "_rdata"},   cpu_rdata, 32'h0);
    chk({tag, "_dvalid"},  32'(disp_valid), 32'd0);
    chk({tag, "_ddata"},   disp_data, 32'h0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_clrdone"}, 32'(clr_done), 32'd0);
    chk({tag, "_ready"},   32'(cpu_ready), 32'd1);
    rst = 1'b0;
  endtask

  initial begin
    int          n_busy;
    int          n_done;
    logic [31:0] fill;
    logic        finished;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 32'h0;
    cpu_wdata = 32'h0; disp_en = 1'b0; disp_addr = 4'h0; clr_start = 1'b0; clr_value = 32'h0;
    m_rvalid = 1'b0; m_rdata = 32'h0; m_dvalid = 1'b0; m_disp = 32'h0;
    for (int i = 0; i < int'(TB_DEPTH); i++) mem_m[i] = 32'h0;
    step();
    step();
    do_reset("reset");

    // Give every word a known value.
    for (int i = 0; i < int'(TB_DEPTH); i++) cpu_wr("init", TB_BASE + 32'(4 * i), $urandom, 4'hF);

    // Byte-enable merge.
    cpu_wr("be_full", 32'h0000_1008, 32'h1122_3344, 4'b1111);
    cpu_wr("be_part", 32'h0000_1008, 32'hAABB_CCDD, 4'b0101);
    cpu_rd("be_rd", 32'h0000_1008);
    chk("be_const", cpu_rdata, 32'h11BB_33DD);
    cpu_wr("be_none", 32'h0000_1008, 32'h0, 4'b0000);

    // Window miss.
    cpu_rd("miss_rd", 32'h0000_2008);
    chk("miss_const", cpu_rdata, 32'h0);
    cpu_wr("miss_wr", 32'h0000_2008, 32'hDEAD_BEEF, 4'hF);
    cpu_rd("miss_chk", 32'h0000_1008);
    chk("miss_keep", cpu_rdata, 32'h11BB_33DD);
    cyc("hold");

    // Back-to-back reads of words 0,1,2.
    cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = TB_BASE + 32'(4 * i);
      cyc("b2b");
    end
    cpu_req = 1'b0;
    cyc("b2b_end");

    // Display read colliding with a CPU write to the same word.
    disp_en = 1'b1; disp_addr = 4'd3;
    cpu_wr("coll", TB_BASE + 32'd12, 32'h0000_0005, 4'hF);
    cyc("coll_new");
    chk("coll_const", disp_data, 32'h0000_0005);
    disp_en = 1'b0;

    // Randomized mixed traffic on both ports.
    for (int i = 0; i < 120; i++) begin
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_be    = 4'($urandom);
      cpu_wdata = $urandom;
      cpu_addr  = ($urandom_range(0, 3) != 0) ? TB_BASE + 32'($urandom_range(0, 63)) : $urandom;
      disp_en   = 1'($urandom_range(0, 1));
      disp_addr = 4'($urandom);
      cyc("rnd");
    end
    cpu_req = 1'b0; disp_en = 1'b0;
    cyc("rnd_end");

    // Full clear sweep with rejected CPU traffic and live display reads.
    fill = 32'hFFFF_FFFF;
    clr_value = fill; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("clr_busy0", 32'(busy), 32'd1);
    chk("clr_done0", 32'(clr_done), 32'd0);
    n_busy = 1; n_done = 0; finished = 1'b0;
    for (int k = 0; k < 40 && !finished; k++) begin
      cpu_req = 1'b1; cpu_we = 1'(k % 2); cpu_addr = TB_BASE; cpu_wdata = 32'h1234_5678; cpu_be = 4'hF;
      clr_start = 1'(k == 3);
      clr_value = 32'h0;
      disp_en = 1'($urandom_range(0, 1)); disp_addr = 4'($urandom);
      chk("clr_ready", 32'(cpu_ready), 32'd0);
      m_dvalid = disp_en;
      if (disp_en) m_disp = mem_m[disp_addr];
      m_rvalid = 1'b0;
      step();
      if (k < int'(TB_DEPTH)) mem_m[k] = fill;
      chk("clr_dvalid", 32'(disp_valid), 32'(m_dvalid));
      chk("clr_ddata", disp_data, m_disp);
      chk("clr_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("clr_rdata", cpu_rdata, m_rdata);
      if (clr_done) n_done++;
      if (busy) n_busy++;
      else finished = 1'b1;
    end
    cpu_req = 1'b0; disp_en = 1'b0; clr_start = 1'b0;
    chk("clr_finished", 32'(finished), 32'd1);
    chk("clr_len", 32'(n_busy), 32'(TB_DEPTH));
    chk("clr_pulse", 32'(n_done), 32'd1);
    cyc("clr_after");
    for (int i = 0; i < int'(TB_DEPTH); i++) begin
      cpu_rd("clr_rd", TB_BASE + 32'(4 * i));
      chk("clr_val", cpu_rdata, 32'hFFFF_FFFF);
    end

    // Reset in the middle of a sweep; a CPU write on the start edge lands first.
    for (int i = 0; i < int'(TB_DEPTH); i++) cpu_wr("pre", TB_BASE + 32'(4 * i), $urandom, 4'hF);
    fill = 32'h0;
    clr_value = fill; clr_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = TB_BASE + 32'd36; cpu_wdata = 32'hCAFE_0009; cpu_be = 4'hF;
    chk("race_ready", 32'(cpu_ready), 32'd1);
    step();
    mem_m[9] = 32'hCAFE_0009;
    clr_start = 1'b0; cpu_req = 1'b0;
    chk("race_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      mem_m[k] = fill;
      chk("mid_busy", 32'(busy), 32'd1);
    end
    do_reset("mid_rst");
    cyc("mid_idle");
    for (int i = 0; i < int'(TB_DEPTH); i++) cpu_rd("mid_rd", TB_BASE + 32'(4 * i));
    chk("mid_w9", mem_m[9], 32'hCAFE_0009);

    // Reset arriving together with a read request.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = TB_BASE + 32'd4;
    do_reset("rd_rst");
    cpu_req = 1'b0;
    cyc("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
